// File: rtl/nvram_pkg.sv
// Shared types and constants for the CMOS NVRAM arbiter.
package nvram_pkg;

  localparam int NVRAM_ADDR_W = 10;
  localparam int NVRAM_DATA_W = 4;
  localparam logic [3:0] UPLOAD_PAD = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WR_PEND,
    RD_PEND,
    RD_CAP
  } nvram_state_e;

endpackage

// File: rtl/nvram_arbiter.sv
// Shares one external CMOS RAM port between the CPU (always wins) and HPS save/restore.
// Optional NVRAM_AUTOSAVE_EN adds a dirty flag tracking CPU writes since the last upload.
module nvram_arbiter
  import nvram_pkg::*;
#(
  parameter int ADDR_W = NVRAM_ADDR_W,
  parameter int DATA_W = NVRAM_DATA_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
`ifdef NVRAM_AUTOSAVE_EN
  output logic              dirty,
`endif
  output logic              overrun
);

  nvram_state_e      state, next_state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              cpu_rd_d;
  logic              wr_req, rd_req, both_flags, conflict;
  logic              capture_wr, capture_rd, hps_we, load_din, set_overrun;

  // Strobes count only inside their own session; both sessions at once is a protocol error.
  assign both_flags = ioctl_download & ioctl_upload;
  assign wr_req     = ioctl_download & ~ioctl_upload & ioctl_wr;
  assign rd_req     = ioctl_upload & ~ioctl_download & ioctl_rd;
  assign conflict   = (wr_req & ioctl_rd) | (rd_req & ioctl_wr);
  assign ioctl_wait = (state != IDLE);

  always_comb begin
    next_state  = state;
    capture_wr  = 1'b0;
    capture_rd  = 1'b0;
    hps_we      = 1'b0;
    load_din    = 1'b0;
    set_overrun = both_flags | conflict;
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          capture_wr = 1'b1;
          next_state = WR_PEND;
        end else if (rd_req) begin
          capture_rd = 1'b1;
          next_state = RD_PEND;
        end
      end
      WR_PEND: begin
        set_overrun = set_overrun | wr_req | rd_req;
        if (!cpu_cs) begin
          hps_we     = 1'b1;
          next_state = IDLE;
        end
      end
      RD_PEND: begin
        set_overrun = set_overrun | wr_req | rd_req;
        if (!cpu_cs) next_state = RD_CAP;
      end
      RD_CAP: begin
        set_overrun = set_overrun | wr_req | rd_req;
        load_din    = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = lat_addr;
    ram_d    = lat_data;
    ram_we   = 1'b0;
    if (cpu_cs) begin
      ram_addr = cpu_addr;
      ram_d    = cpu_din;
      ram_we   = cpu_we & reset_n;
    end else if (hps_we) begin
      ram_we   = reset_n;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_data  <= '0;
      ioctl_din <= 8'hFF;
      cpu_dout  <= '0;
      cpu_rd_d  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state    <= next_state;
      cpu_rd_d <= cpu_cs & ~cpu_we;
      if (capture_wr) begin
        lat_addr <= ioctl_addr;
        lat_data <= ioctl_dout[DATA_W-1:0];
      end else if (capture_rd) begin
        lat_addr <= ioctl_addr;
      end
      if (load_din) ioctl_din <= {UPLOAD_PAD, ram_q};
      if (cpu_rd_d) cpu_dout <= ram_q;
      if (set_overrun) overrun <= 1'b1;
    end
  end

`ifdef NVRAM_AUTOSAVE_EN
  logic upload_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      upload_d <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      upload_d <= ioctl_upload;
      if (cpu_cs && cpu_we) dirty <= 1'b1;
      else if (upload_d && !ioctl_upload) dirty <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nvram_arbiter.sv
// Directed self-checking bench for nvram_arbiter with a behavioural 1-cycle-read RAM.
// Define NVRAM_AUTOSAVE_EN to also exercise the dirty flag.
module tb_nvram_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       cpu_cs, cpu_we;
  logic [9:0] cpu_addr;
  logic [3:0] cpu_din, cpu_dout;
  logic       ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
  logic [9:0] ioctl_addr;
  logic [7:0] ioctl_dout, ioctl_din;
  logic       ioctl_wait;
  logic [9:0] ram_addr;
  logic [3:0] ram_d, ram_q;
  logic       ram_we, overrun;
`ifdef NVRAM_AUTOSAVE_EN
  logic       dirty;
`endif

  int checks = 0;
  int failures = 0;

  logic [3:0] mem [1024];

  nvram_arbiter #(.ADDR_W(10), .DATA_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
`ifdef NVRAM_AUTOSAVE_EN
    .dirty(dirty),
`endif
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // External RAM model; cleared while reset is held so the bench starts from known contents.
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 1024; i++) mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // HPS download of one byte with the CPU idle; leaves the arbiter back in IDLE.
  task automatic hps_write(input logic [9:0] a, input logic [7:0] d);
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
  endtask

  // HPS upload of one byte; checks ioctl_din once ioctl_wait has fallen.
  task automatic hps_read(input string tag, input logic [9:0] a, input logic [7:0] exp_din);
    ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    tick();
    tick();
    settle();
    check({tag, "_wait"}, 32'(ioctl_wait), 32'h0);
    check({tag, "_din"}, 32'(ioctl_din), 32'(exp_din));
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h001; cpu_din = 4'h5;
    ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_wr = 1'b0; ioctl_rd = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick();
    tick();
    settle();
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_wait", 32'(ioctl_wait), 32'h0);
    check("rst_din", 32'(ioctl_din), 32'hFF);
    check("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
`ifdef NVRAM_AUTOSAVE_EN
    check("rst_dirty", 32'(dirty), 32'h0);
`endif
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Download 0x3A to 0x005: one ram_we pulse with the low nibble, wait high one cycle.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 10'h005; ioctl_dout = 8'h3A;
    settle();
    check("dl_no_early_we", 32'(ram_we), 32'h0);
    tick();
    ioctl_wr = 1'b0;
    settle();
    check("dl_wait_hi", 32'(ioctl_wait), 32'h1);
    check("dl_we", 32'(ram_we), 32'h1);
    check("dl_addr", 32'(ram_addr), 32'h005);
    check("dl_d", 32'(ram_d), 32'hA);
    tick();
    settle();
    check("dl_wait_lo", 32'(ioctl_wait), 32'h0);
    check("dl_we_lo", 32'(ram_we), 32'h0);

    // Contention: CPU write takes cycle n+1, HPS write slips to n+2.
    ioctl_wr = 1'b1; ioctl_addr = 10'h010; ioctl_dout = 8'h05;
    tick();
    ioctl_wr = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_din = 4'h9;
    settle();
    check("ct_cpu_addr", 32'(ram_addr), 32'h020);
    check("ct_cpu_d", 32'(ram_d), 32'h9);
    check("ct_cpu_we", 32'(ram_we), 32'h1);
    check("ct_wait_n1", 32'(ioctl_wait), 32'h1);
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    settle();
    check("ct_hps_addr", 32'(ram_addr), 32'h010);
    check("ct_hps_d", 32'(ram_d), 32'h5);
    check("ct_hps_we", 32'(ram_we), 32'h1);
    tick();
    settle();
    check("ct_wait_lo", 32'(ioctl_wait), 32'h0);
    check("ct_overrun", 32'(overrun), 32'h0);
    ioctl_download = 1'b0;
`ifdef NVRAM_AUTOSAVE_EN
    check("dirty_after_cpu_wr", 32'(dirty), 32'h1);
`endif

    // Upload: preload 0x3FF with 7, then read back top address and the earlier writes.
    hps_write(10'h3FF, 8'h47);
    settle();
    check("ul_rd_pend_wait", 32'(ioctl_wait), 32'h0);
    ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 10'h3FF;
    tick();
    ioctl_rd = 1'b0;
    settle();
    check("ul_pend_addr", 32'(ram_addr), 32'h3FF);
    check("ul_pend_we", 32'(ram_we), 32'h0);
    check("ul_pend_wait", 32'(ioctl_wait), 32'h1);
    tick();
    settle();
    check("ul_cap_wait", 32'(ioctl_wait), 32'h1);
    tick();
    settle();
    check("ul_3ff_wait", 32'(ioctl_wait), 32'h0);
    check("ul_3ff_din", 32'(ioctl_din), 32'hF7);
    hps_read("ul_005", 10'h005, 8'hFA);
    hps_read("ul_010", 10'h010, 8'hF5);
    ioctl_upload = 1'b0;
    tick();
    settle();
    check("ul_din_hold", 32'(ioctl_din), 32'hF5);
`ifdef NVRAM_AUTOSAVE_EN
    check("dirty_after_upload", 32'(dirty), 32'h0);
`endif

    // CPU read: data appears on cpu_dout two edges after the strobe and then holds.
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    tick();
    cpu_cs = 1'b0;
    tick();
    settle();
    check("cpu_rd_dout", 32'(cpu_dout), 32'h9);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h030; cpu_din = 4'h2;
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
    settle();
    check("cpu_dout_hold", 32'(cpu_dout), 32'h9);

    // ioctl_wr without a download session is ignored.
    ioctl_wr = 1'b1; ioctl_addr = 10'h040; ioctl_dout = 8'h0E;
    settle();
    check("ign_we", 32'(ram_we), 32'h0);
    tick();
    ioctl_wr = 1'b0;
    settle();
    check("ign_wait", 32'(ioctl_wait), 32'h0);
    check("ign_overrun", 32'(overrun), 32'h0);

    // Overrun: second strobe during WR_PEND is dropped, first write completes.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 10'h0AA; ioctl_dout = 8'h0C;
    tick();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000;
    ioctl_addr = 10'h0BB; ioctl_dout = 8'h0D;
    settle();
    check("ov_cpu_rd_we", 32'(ram_we), 32'h0);
    tick();
    cpu_cs = 1'b0; ioctl_wr = 1'b0;
    settle();
    check("ov_first_addr", 32'(ram_addr), 32'h0AA);
    check("ov_first_d", 32'(ram_d), 32'hC);
    check("ov_first_we", 32'(ram_we), 32'h1);
    tick();
    settle();
    check("ov_flag", 32'(overrun), 32'h1);
    check("ov_wait_lo", 32'(ioctl_wait), 32'h0);
    ioctl_download = 1'b0;
    hps_read("ov_0aa", 10'h0AA, 8'hFC);
    hps_read("ov_0bb", 10'h0BB, 8'hF0);

    // Reset while a read is pending abandons it cleanly.
    ioctl_rd = 1'b1; ioctl_addr = 10'h0AA;
    tick();
    ioctl_rd = 1'b0;
    settle();
    check("rm_pend_wait", 32'(ioctl_wait), 32'h1);
    reset_n = 1'b0;
    settle();
    check("rm_wait", 32'(ioctl_wait), 32'h0);
    check("rm_din", 32'(ioctl_din), 32'hFF);
    check("rm_we", 32'(ram_we), 32'h0);
    check("rm_overrun", 32'(overrun), 32'h0);
    ioctl_upload = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Simultaneous wr/rd in a download session: write proceeds, overrun flags it.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_rd = 1'b1;
    ioctl_addr = 10'h001; ioctl_dout = 8'h06;
    tick();
    ioctl_wr = 1'b0; ioctl_rd = 1'b0;
    settle();
    check("sim_we", 32'(ram_we), 32'h1);
    check("sim_d", 32'(ram_d), 32'h6);
    check("sim_overrun", 32'(overrun), 32'h1);
    tick();
    ioctl_download = 1'b0;

    // Both session flags: no access, overrun set (after a reset to clear the sticky flag).
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ioctl_download = 1'b1; ioctl_upload = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 10'h002;
    tick();
    ioctl_wr = 1'b0;
    settle();
    check("both_we", 32'(ram_we), 32'h0);
    check("both_wait", 32'(ioctl_wait), 32'h0);
    check("both_overrun", 32'(overrun), 32'h1);
    ioctl_download = 1'b0; ioctl_upload = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
